// File: rtl/pwm_decoder.sv
// PWM input decoder: measures high time and rise-to-rise period in clock cycles.
// Define PWM_DECODER_FILTER_EN to insert a FILT_LEN-cycle glitch filter ahead of edge detection.
module pwm_decoder #(
   parameter int CNT_W    = 16,
   parameter int TIMEOUT  = 1000,
   parameter int FILT_LEN = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm_in,
   input  logic             enable,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic             sample_valid,
   output logic             timeout
);

   typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   if (TIMEOUT < 2 || FILT_LEN < 2) begin : g_bad_param
      $error("pwm_decoder: TIMEOUT and FILT_LEN must both be at least 2");
   end

   logic             sync1_q;
   logic             sync2_q;
   logic             s;
   logic             sD_q;
   logic             rise_q;
   logic             fall_q;
   state_t           state_q;
   logic [CNT_W-1:0] perCnt_q;
   logic [CNT_W-1:0] hiTmp_q;
   logic [CNT_W-1:0] highCnt_q;
   logic [CNT_W-1:0] periodCnt_q;
   logic             sampleValid_q;
   logic             timeout_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= pwm_in;
         sync2_q <= sync1_q;
      end
   end

`ifdef PWM_DECODER_FILTER_EN
   localparam int FW = $clog2(FILT_LEN);
   localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);

   logic          filt_q;
   logic [FW-1:0] filtCnt_q;

   // The filtered level flips only after FILT_LEN consecutive disagreeing samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_q    <= 1'b0;
         filtCnt_q <= '0;
      end else if (sync2_q == filt_q) begin
         filtCnt_q <= '0;
      end else if (filtCnt_q == FILT_MAX) begin
         filt_q    <= sync2_q;
         filtCnt_q <= '0;
      end else begin
         filtCnt_q <= filtCnt_q + 1'b1;
      end
   end

   assign s = filt_q;
`else
   assign s = sync2_q;
`endif

   // Edge pulses are registered so the FSM decodes from flops, not the synchronizer path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sD_q   <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sD_q   <= s;
         rise_q <= s & ~sD_q;
         fall_q <= ~s & sD_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         perCnt_q      <= '0;
         hiTmp_q       <= '0;
         highCnt_q     <= '0;
         periodCnt_q   <= '0;
         sampleValid_q <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         sampleValid_q <= 1'b0;
         if (!enable) begin
            state_q   <= IDLE;
            timeout_q <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (rise_q) begin
                     perCnt_q <= CNT_W'(1);
                     state_q  <= MEAS_HIGH;
                  end
               end
               MEAS_HIGH: begin
                  if (perCnt_q == TIMEOUT_C) begin
                     timeout_q <= 1'b1;
                     state_q   <= IDLE;
                  end else begin
                     perCnt_q <= perCnt_q + 1'b1;
                     if (fall_q) begin
                        hiTmp_q <= perCnt_q;
                        state_q <= MEAS_LOW;
                     end
                  end
               end
               MEAS_LOW: begin
                  // A rise on the timeout cycle still completes a valid period.
                  if (rise_q) begin
                     highCnt_q     <= hiTmp_q;
                     periodCnt_q   <= perCnt_q;
                     sampleValid_q <= 1'b1;
                     timeout_q     <= 1'b0;
                     perCnt_q      <= CNT_W'(1);
                     state_q       <= MEAS_HIGH;
                  end else if (perCnt_q == TIMEOUT_C) begin
                     timeout_q <= 1'b1;
                     state_q   <= IDLE;
                  end else begin
                     perCnt_q <= perCnt_q + 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign high_cnt     = highCnt_q;
   assign period_cnt   = periodCnt_q;
   assign sample_valid = sampleValid_q;
   assign timeout      = timeout_q;

endmodule

// File: doc/pwm_decoder.md
# pwm_decoder

Measures an incoming PWM waveform, such as an RC receiver channel or a looped-back motor drive line, and reports its high time and period in clock cycles. It is the receive-side counterpart to the drone SoC PWM output path. It sits between an external PWM pin and the control logic. Each completed period produces one registered measurement with a single-cycle valid strobe. A loss-of-signal timeout flag is also provided.

## Interface
- CNT_W, 16: width of the measurement counters and outputs.
- TIMEOUT, 1000: cycles without a rising edge before signal loss is declared. Legal range is 2 ≤ TIMEOUT ≤ 2^CNT_W−1.
- FILT_LEN, 3: glitch-filter length in cycles. Used only when PWM_DECODER_FILTER_EN is defined. Minimum 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pwm_in  in  1  asynchronous PWM input.
- enable  in  1  decoder enable; low forces the IDLE state.
- high_cnt  out  CNT_W  high time of the last complete period, in cycles.
- period_cnt  out  CNT_W  rise-to-rise period of the last complete period, in cycles.
- sample_valid  out  1  one-cycle pulse when high_cnt and period_cnt update.
- timeout  out  1  level; set when no rising edge is seen for TIMEOUT cycles.

## Operation
- **Input conditioning:**
  - pwm_in passes through a 2-flop synchronizer to give s.
  - A registered copy s_d is kept.
  - rise = s & ~s_d; fall = ~s & s_d.
- **Counters:**
  - per_cnt is set to 1 on the cycle rise is detected and increments by 1 on every other cycle.
  - On a fall in MEAS_HIGH, hi_tmp <= per_cnt.
  - For a steady input that is high for H cycles and low for L cycles: high_cnt = H and period_cnt = H+L.
- **FSM states:** IDLE, MEAS_HIGH, MEAS_LOW.
  - IDLE, on rise: go to MEAS_HIGH. The first rise after IDLE never produces a sample.
  - MEAS_HIGH, on fall: capture hi_tmp, go to MEAS_LOW.
  - MEAS_LOW, on rise: register high_cnt <= hi_tmp and period_cnt <= per_cnt, pulse sample_valid, clear timeout, go to MEAS_HIGH.
  - MEAS_HIGH or MEAS_LOW, when per_cnt == TIMEOUT with no rise on that cycle: set timeout, go to IDLE, no sample_valid.
- **Boundary conditions:**
  - A rise on the same cycle per_cnt reaches TIMEOUT takes priority: the sample is valid and no timeout is raised.
  - A constant-high input times out from MEAS_HIGH.
  - A constant-low input times out from MEAS_LOW.
  - per_cnt never exceeds TIMEOUT, so no saturation logic is needed.
- **Enable:**
  - enable low: state goes to IDLE, sample_valid=0, timeout=0, high_cnt and period_cnt hold.
  - The first measurement after enable rises needs two rises.
- **Reset:** asynchronous; takes effect immediately in any state, including mid-period.
  - All outputs go to 0, state goes to IDLE, and per_cnt, hi_tmp, synchronizer and filter all go to 0.
  - Partial measurements are discarded.

## Timing
- **Latency, filter compiled out:** sample_valid and the new counts appear 3 clk cycles after the first clk edge at which pwm_in is sampled high.
- **Latency, filter compiled in:** FILT_LEN cycles are added.
- **Strobe:** sample_valid is high for exactly one cycle per period. Outputs are stable until the next strobe.
- **Timeout:** the timeout flag rises on the cycle after per_cnt reaches TIMEOUT.
- **Input rate:**
  - Minimum measurable high or low width is 1 cycle with the filter out, FILT_LEN cycles with it in.
  - Inputs toggling faster than that are undefined without the filter.
  - With the filter, such inputs are suppressed.

## Configuration
- PWM_DECODER_FILTER_EN defined:
  - A glitch filter sits between the synchronizer and edge detect.
  - The filtered level changes only after FILT_LEN consecutive synchronizer samples disagree with it.
  - Pulses shorter than FILT_LEN cycles are ignored.
  - Widths of clean pulses are unchanged; latency grows by FILT_LEN cycles.
- Undefined: s is the raw synchronizer output and FILT_LEN is unused.

## Test plan
Benches use CNT_W=16, TIMEOUT=1000 and FILT_LEN=3 throughout.
- **Reset:** assert rst with pwm_in toggling → high_cnt=0, period_cnt=0, sample_valid=0, timeout=0 immediately, and no strobe until two rises after release.
- **Steady waveform:** pwm_in high 20 / low 236, enable=1 → first strobe on the second rise, with high_cnt=20, period_cnt=256. Repeats every 256 cycles, 3 cycles after each rise (filter out).
- **Loss of signal:** after valid samples, hold pwm_in low → timeout=1 at 1000 cycles after the last rise, no strobe. Restart at 50/150 → timeout clears on the strobe with high_cnt=50, period_cnt=200.
- **Edge vs. timeout priority:** a period of exactly 1000 cycles with high 10 → strobe with period_cnt=1000, timeout stays 0.
- **Glitch:** a 1-cycle high glitch inside a 30/226 low phase:
  - Filter in → ignored; high_cnt=30, period_cnt=256.
  - Filter out → extra strobe.
- **Mid-operation disturbances:**
  - Pulse rst for 1 cycle during MEAS_LOW → outputs 0, and the next rise yields no strobe.
  - Drop enable for 10 cycles → timeout cleared, counts held.
